sram_ctrl: RTL and testbench
============================

# sram_ctrl

Host-side initiator for the 64×8 single-port static RAM. Converts a simple request/done handshake into the RAM's chip-enable, read/write, address and shared tri-state data bus sequence. Owns the bidirectional data bus: drives it only during write cycles and releases it (high-Z) otherwise. Sits between user logic and the RAM instance, one controller per RAM.

## Interface
- ADDR_W, 6, RAM address width (64 words)
- DATA_W, 8, RAM word width
- i_clk  in  1  system clock, all logic on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_req  in  1  request strobe, sampled only while o_busy=0
- i_wr  in  1  1=write, 0=read; sampled with i_req
- i_addr  in  ADDR_W  request address
- i_wdata  in  DATA_W  write data
- o_busy  out  1  transaction in progress; requests ignored
- o_done  out  1  one-cycle pulse at transaction completion
- o_rdata  out  DATA_W  read result, valid from o_done, held until next read completes
- o_ram_ce  out  1  RAM chip enable
- o_ram_rw  out  1  RAM read/write select
- o_ram_addr  out  ADDR_W  RAM address
- io_ram_data  inout  DATA_W  shared RAM data bus
- i_bist_start, o_bist_done, o_bist_fail: present only with SRAM_CTRL_BIST_EN (see Configuration)

## Operation
- RAM protocol: write = ce=1, rw=1, addr and data on bus, RAM captures at rising edge. Read = address phase (ce=1, rw=0; RAM registers address at edge) then data phase (ce=0, rw=1; RAM drives bus, controller samples at end of phase).
- FSM states: IDLE, WRITE, RD_ADDR, RD_DATA (plus BIST states when enabled).
- IDLE: ce=0, rw=0, bus released. i_req=1 → latch i_wr/i_addr/i_wdata; go WRITE if i_wr else RD_ADDR.
- WRITE: ce=1, rw=1, drive latched data onto io_ram_data → IDLE, assert o_done.
- RD_ADDR: ce=1, rw=0, bus released → RD_DATA.
- RD_DATA: ce=0, rw=1, bus released; capture io_ram_data into o_rdata → IDLE, assert o_done.
- o_busy=1 in every non-IDLE state. i_req while busy is dropped, not queued.
- o_ram_addr holds latched address; unchanged in IDLE.
- Bus driver enable is a registered flag set only in WRITE; never asserted together with rw=0.

## Timing
- Reset (async, immediate): state IDLE, o_ram_ce=0, o_ram_rw=0, o_ram_addr=0, bus high-Z, o_busy=0, o_done=0, o_rdata=0, BIST outputs 0. Reset mid-transaction aborts; no completion pulse.
- Request accepted at edge N (i_req=1, state IDLE).
- Write: WRITE in cycle N+1, o_done high in cycle N+2.
- Read: RD_ADDR cycle N+1, RD_DATA cycle N+2, o_done and new o_rdata in cycle N+3.
- Back-to-back: i_req high during the o_done cycle is accepted (state already IDLE); write throughput 1 per 2 cycles, read 1 per 3.
- All outputs registered; no combinational path from host inputs to RAM pins.

## Configuration
- SRAM_CTRL_BIST_EN defined: adds i_bist_start (in, 1), o_bist_done (out, 1, one-cycle pulse), o_bist_fail (out, 1, sticky). i_bist_start in IDLE starts self-test; wins over simultaneous i_req. Writes addresses 0..63 ascending with data addr ^ 8'hA5, then reads 0..63 and compares; any mismatch sets o_bist_fail. Address counter wrap 63→0 ends each phase. 192 busy cycles; o_bist_done pulses the following cycle. o_bist_fail cleared at next start and on reset. Host requests ignored (o_busy=1) during BIST.
- Not defined: BIST ports and states absent; behaviour otherwise identical.

## Structure
- Package sram_pkg: ADDR_W, DATA_W, state enum, BIST_PATTERN = 8'hA5, MEM_DEPTH = 64.
- One sub-module: sram_bist_seq (address counter, phase flag, pattern generate/compare), instantiated only under SRAM_CTRL_BIST_EN.

## Test plan
- Write 8'h3C to addr 5, then read addr 5 → o_done at N+2 then N+3, o_rdata=8'h3C; bus high-Z outside WRITE.
- Write addr 0 and addr 63 with 8'h00/8'hFF, read both → exact values returned, no aliasing.
- i_req held high during busy with different addr → only first request executes, one o_done.
- i_req asserted in o_done cycle → accepted, second o_done exactly 2 (write) or 3 (read) cycles later.
- Assert i_rst_n=0 during RD_DATA → outputs immediately at reset values, no o_done, bus high-Z.
- BIST (macro on) with good RAM → o_bist_done after 192 busy cycles, o_bist_fail=0; force RAM addr 17 bit stuck → o_bist_fail=1.

Source files
------------

// File: rtl/sram_pkg.sv
// sram_pkg -- shared definitions for the 64x8 SRAM initiator slice.
//
// Contents:
//   ADDR_W, DATA_W   RAM address / word widths
//   MEM_DEPTH        number of RAM words
//   BIST_PATTERN     XOR mask used to derive self-test data from the address
//   state_t          controller FSM states (BIST states only with SRAM_CTRL_BIST_EN)
//   bistPattern()    expected self-test word for a given address
//
// Optional feature macro: SRAM_CTRL_BIST_EN
package sram_pkg;

  localparam int ADDR_W    = 6;
  localparam int DATA_W    = 8;
  localparam int MEM_DEPTH = 64;

  localparam logic [DATA_W-1:0] BIST_PATTERN = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_ADDR,
    RD_DATA
`ifdef SRAM_CTRL_BIST_EN
    ,
    BIST_WR,
    BIST_RA,
    BIST_RD
`endif
  } state_t;

  // Self-test data is the zero-extended address XORed with the pattern, so
  // every word differs from its neighbours and from the all-zero/all-one case.
  function automatic logic [DATA_W-1:0] bistPattern(input logic [ADDR_W-1:0] addr);
    return {{(DATA_W-ADDR_W){1'b0}}, addr} ^ BIST_PATTERN;
  endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// sram_ctrl_if -- host-side request/done handshake of the SRAM initiator.
//
// Signals (named from the controller's point of view):
//   i_req    request strobe, sampled only while o_busy=0
//   i_wr     1=write, 0=read
//   i_addr   request address
//   i_wdata  write data
//   o_busy   transaction in progress
//   o_done   one-cycle completion pulse
//   o_rdata  last read result
//
// Modports: master = user logic issuing requests, slave = sram_ctrl.
interface sram_ctrl_if;
  import sram_pkg::*;

  logic              i_req;
  logic              i_wr;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_wdata;
  logic              o_busy;
  logic              o_done;
  logic [DATA_W-1:0] o_rdata;

  modport master (
    output i_req, i_wr, i_addr, i_wdata,
    input  o_busy, o_done, o_rdata
  );

  modport slave (
    input  i_req, i_wr, i_addr, i_wdata,
    output o_busy, o_done, o_rdata
  );

endinterface

// File: rtl/sram_bist_seq.sv
// sram_bist_seq -- address sequencer and checker for the SRAM self-test.
//
// Only built with SRAM_CTRL_BIST_EN defined.
//
// Ports:
//   i_clk, i_rst_n   clock / asynchronous active-low reset
//   i_start          begin a new self-test (clears address, phase, fail)
//   i_step           advance to the next address (wraps 63 -> 0)
//   i_check          compare i_rdata against the current address' pattern
//   i_rdata          word returned by the RAM
//   o_next_addr      address that follows the current one
//   o_next_pattern   pattern belonging to o_next_addr
//   o_last           current address is the final word
//   o_fail           sticky mismatch flag
`ifdef SRAM_CTRL_BIST_EN
module sram_bist_seq import sram_pkg::*; (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_step,
  input  logic              i_check,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [ADDR_W-1:0] o_next_addr,
  output logic [DATA_W-1:0] o_next_pattern,
  output logic              o_last,
  output logic              o_fail
);

  logic [ADDR_W-1:0] r_addr;
  logic              r_phase;
  logic              r_fail;
  logic [ADDR_W-1:0] w_next_addr;

  assign w_next_addr    = r_addr + 1'b1;
  assign o_next_addr    = w_next_addr;
  assign o_next_pattern = bistPattern(w_next_addr);
  assign o_last         = (r_addr == ADDR_W'(MEM_DEPTH-1));
  assign o_fail         = r_fail;

  // The address register mirrors the word currently presented to the RAM.
  // Stepping from the last word wraps to 0, which is what hands the write
  // phase over to the read phase. Comparisons only count in the read phase,
  // and a mismatch stays latched until the next start.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr  <= '0;
      r_phase <= 1'b0;
      r_fail  <= 1'b0;
    end else if (i_start) begin
      r_addr  <= '0;
      r_phase <= 1'b0;
      r_fail  <= 1'b0;
    end else begin
      if (i_step) begin
        r_addr <= w_next_addr;
      end
      if (i_step && o_last && !r_phase) begin
        r_phase <= 1'b1;
      end
      if (i_check && r_phase && (i_rdata != bistPattern(r_addr))) begin
        r_fail <= 1'b1;
      end
    end
  end

endmodule
`endif

// File: rtl/sram_ctrl.sv
// sram_ctrl -- host-side initiator for a 64x8 single-port static RAM.
//
// Turns the request/done handshake on io_host into the RAM's chip-enable,
// read/write, address and shared data bus sequence. The data bus is driven
// only while a write is on the pins and is high-Z otherwise.
//
// Ports:
//   i_clk, i_rst_n   clock / asynchronous active-low reset
//   io_host          sram_ctrl_if.slave host handshake
//   o_ram_ce         RAM chip enable
//   o_ram_rw         RAM read/write select
//   o_ram_addr       RAM address (holds the last latched address)
//   io_ram_data      shared RAM data bus
//   i_bist_start, o_bist_done, o_bist_fail   self-test control/status
//
// Optional feature macro: SRAM_CTRL_BIST_EN adds the self-test ports/states.
module sram_ctrl import sram_pkg::*; (
  input  logic              i_clk,
  input  logic              i_rst_n,
  sram_ctrl_if.slave        io_host,
  output logic              o_ram_ce,
  output logic              o_ram_rw,
  output logic [ADDR_W-1:0] o_ram_addr,
  inout  wire  [DATA_W-1:0] io_ram_data
`ifdef SRAM_CTRL_BIST_EN
  ,
  input  logic              i_bist_start,
  output logic              o_bist_done,
  output logic              o_bist_fail
`endif
);

  state_t            r_state;
  logic              r_ram_ce;
  logic              r_ram_rw;
  logic [ADDR_W-1:0] r_ram_addr;
  logic              r_drive;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_busy;
  logic              r_done;

  // The bus driver is a registered enable that is only ever set alongside
  // rw=1, so the controller can never fight the RAM during its data phase.
  assign io_ram_data = r_drive ? r_wdata : {DATA_W{1'bz}};

  assign o_ram_ce        = r_ram_ce;
  assign o_ram_rw        = r_ram_rw;
  assign o_ram_addr      = r_ram_addr;
  assign io_host.o_busy  = r_busy;
  assign io_host.o_done  = r_done;
  assign io_host.o_rdata = r_rdata;

`ifdef SRAM_CTRL_BIST_EN
  logic              r_bist_done;
  logic              w_seq_start;
  logic              w_seq_step;
  logic              w_seq_check;
  logic [ADDR_W-1:0] w_next_addr;
  logic [DATA_W-1:0] w_next_pattern;
  logic              w_last;
  logic              w_fail;

  // Self-test start is taken in IDLE ahead of any host request. The
  // sequencer advances once per write cycle and once per completed read.
  assign w_seq_start = (r_state == IDLE) && i_bist_start;
  assign w_seq_step  = (r_state == BIST_WR) || (r_state == BIST_RD);
  assign w_seq_check = (r_state == BIST_RD);

  assign o_bist_done = r_bist_done;
  assign o_bist_fail = w_fail;

  sram_bist_seq u_bist_seq (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_start        (w_seq_start),
    .i_step         (w_seq_step),
    .i_check        (w_seq_check),
    .i_rdata        (io_ram_data),
    .o_next_addr    (w_next_addr),
    .o_next_pattern (w_next_pattern),
    .o_last         (w_last),
    .o_fail         (w_fail)
  );
`endif

  // Main controller FSM. Every RAM pin and host status output is a register
  // updated here, so nothing on the host side reaches the RAM pins without
  // passing through a flop. A write occupies one cycle on the pins; a read
  // spends one cycle presenting the address and one cycle with the RAM
  // driving the bus, and the bus is sampled at the end of that second cycle.
  // o_done is a single-cycle pulse, cleared on every edge unless re-set.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_ram_ce   <= 1'b0;
      r_ram_rw   <= 1'b0;
      r_ram_addr <= '0;
      r_drive    <= 1'b0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef SRAM_CTRL_BIST_EN
      r_bist_done <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef SRAM_CTRL_BIST_EN
      r_bist_done <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
`ifdef SRAM_CTRL_BIST_EN
          if (i_bist_start) begin
            r_state    <= BIST_WR;
            r_ram_addr <= '0;
            r_wdata    <= bistPattern('0);
            r_ram_ce   <= 1'b1;
            r_ram_rw   <= 1'b1;
            r_drive    <= 1'b1;
            r_busy     <= 1'b1;
          end else
`endif
          if (io_host.i_req) begin
            r_ram_addr <= io_host.i_addr;
            r_wdata    <= io_host.i_wdata;
            r_ram_ce   <= 1'b1;
            r_busy     <= 1'b1;
            if (io_host.i_wr) begin
              r_state  <= WRITE;
              r_ram_rw <= 1'b1;
              r_drive  <= 1'b1;
            end else begin
              r_state  <= RD_ADDR;
              r_ram_rw <= 1'b0;
            end
          end
        end
        WRITE: begin
          r_state  <= IDLE;
          r_ram_ce <= 1'b0;
          r_ram_rw <= 1'b0;
          r_drive  <= 1'b0;
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
        end
        RD_ADDR: begin
          r_state  <= RD_DATA;
          r_ram_ce <= 1'b0;
          r_ram_rw <= 1'b1;
        end
        RD_DATA: begin
          r_state  <= IDLE;
          r_rdata  <= io_ram_data;
          r_ram_rw <= 1'b0;
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
        end
`ifdef SRAM_CTRL_BIST_EN
        BIST_WR: begin
          r_ram_addr <= w_next_addr;
          r_wdata    <= w_next_pattern;
          if (w_last) begin
            r_state  <= BIST_RA;
            r_ram_rw <= 1'b0;
            r_drive  <= 1'b0;
          end
        end
        BIST_RA: begin
          r_state  <= BIST_RD;
          r_ram_ce <= 1'b0;
          r_ram_rw <= 1'b1;
        end
        BIST_RD: begin
          if (w_last) begin
            r_state     <= IDLE;
            r_ram_rw    <= 1'b0;
            r_busy      <= 1'b0;
            r_bist_done <= 1'b1;
          end else begin
            r_state    <= BIST_RA;
            r_ram_addr <= w_next_addr;
            r_ram_ce   <= 1'b1;
            r_ram_rw   <= 1'b0;
          end
        end
`endif
        default: begin
          r_state  <= IDLE;
          r_ram_ce <= 1'b0;
          r_ram_rw <= 1'b0;
          r_drive  <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl -- self-checking bench for sram_ctrl with a behavioural
// 64x8 RAM on a pulled-up shared bus (a released bus reads 8'hFF).
module tb_sram_ctrl;

  logic       clock;
  logic       rstN;
  logic       ramCe;
  logic       ramRw;
  logic [5:0] ramAddr;
  wire  [7:0] ramBus;
  logic       bistStart;
  logic       bistDone;
  logic       bistFail;
  logic       stuckFault;

  int errors;
  int checks;

  logic [7:0] refMem [64];

  sram_ctrl_if hostIf ();

  sram_ctrl dut (
    .i_clk        (clock),
    .i_rst_n      (rstN),
    .io_host      (hostIf),
    .o_ram_ce     (ramCe),
    .o_ram_rw     (ramRw),
    .o_ram_addr   (ramAddr),
    .io_ram_data  (ramBus)
`ifdef SRAM_CTRL_BIST_EN
    ,
    .i_bist_start (bistStart),
    .o_bist_done  (bistDone),
    .o_bist_fail  (bistFail)
`endif
  );

`ifndef SRAM_CTRL_BIST_EN
  assign bistDone = 1'b0;
  assign bistFail = 1'b0;
`endif

  // Free-running 100 MHz clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural RAM: write when ce=1/rw=1, register the address when
  // ce=1/rw=0, drive the registered word while ce=0/rw=1. When stuckFault
  // is set, bit 0 of word 17 reads back as 1.
  logic [7:0] ramMem [64] = '{default: 8'h00};
  logic [5:0] ramAddrReg = 6'd0;
  logic [7:0] ramOut;

  pullup busPull (ramBus);

  always @(posedge clock) begin
    if (ramCe && ramRw) ramMem[ramAddr] <= ramBus;
    if (ramCe && !ramRw) ramAddrReg <= ramAddr;
  end

  assign ramOut = (stuckFault && ramAddrReg == 6'd17) ? (ramMem[ramAddrReg] | 8'h01)
                                                      : ramMem[ramAddrReg];
  assign ramBus = (!ramCe && ramRw) ? ramOut : 8'hzz;

  // One comparison: count it, and report a failure through the assertion.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Issue one host transaction starting in the current (IDLE) cycle and
  // follow it cycle by cycle until its o_done cycle, where the task returns.
  task automatic applyStimulus(input logic wr, input logic [5:0] addr,
                               input logic [7:0] data);
    hostIf.i_req   = 1'b1;
    hostIf.i_wr    = wr;
    hostIf.i_addr  = addr;
    hostIf.i_wdata = data;
    @(negedge clock);
    hostIf.i_req   = 1'b0;
    hostIf.i_addr  = ~addr;
    hostIf.i_wdata = ~data;
    checkOutput("busy_c1", hostIf.o_busy, 1);
    checkOutput("ce_c1", ramCe, 1);
    checkOutput("addr_c1", ramAddr, addr);
    checkOutput("done_c1", hostIf.o_done, 0);
    if (wr) begin
      checkOutput("rw_write", ramRw, 1);
      checkOutput("bus_write", ramBus, data);
      refMem[addr] = data;
      @(negedge clock);
    end else begin
      checkOutput("rw_rdaddr", ramRw, 0);
      checkOutput("bus_rdaddr", ramBus, 8'hFF);
      @(negedge clock);
      checkOutput("busy_rddata", hostIf.o_busy, 1);
      checkOutput("ce_rddata", ramCe, 0);
      checkOutput("rw_rddata", ramRw, 1);
      checkOutput("done_rddata", hostIf.o_done, 0);
      @(negedge clock);
      checkOutput("rdata", hostIf.o_rdata, refMem[addr]);
    end
    checkOutput("done", hostIf.o_done, 1);
    checkOutput("busy_done", hostIf.o_busy, 0);
    checkOutput("ce_done", ramCe, 0);
    checkOutput("bus_done", ramBus, 8'hFF);
    checkOutput("addr_hold", ramAddr, addr);
  endtask

`ifdef SRAM_CTRL_BIST_EN
  // Start a self-test with a competing host request, count busy cycles
  // until o_bist_done, then record the pattern the RAM should now hold.
  task automatic runBist(input logic expFail);
    int busyCycles = 0;
    logic seenDone = 1'b0;
    logic sawHostDone = 1'b0;
    bistStart      = 1'b1;
    hostIf.i_req   = 1'b1;
    hostIf.i_wr    = 1'b1;
    hostIf.i_addr  = 6'd3;
    hostIf.i_wdata = 8'h00;
    @(negedge clock);
    bistStart    = 1'b0;
    hostIf.i_req = 1'b0;
    checkOutput("bist_fail_cleared", bistFail, 0);
    checkOutput("bist_rw_first", ramRw, 1);
    for (int c = 0; c < 400; c++) begin
      if (bistDone) begin
        seenDone = 1'b1;
        break;
      end
      if (hostIf.o_busy) busyCycles++;
      if (hostIf.o_done) sawHostDone = 1'b1;
      @(negedge clock);
    end
    checkOutput("bist_done_seen", seenDone, 1);
    checkOutput("bist_busy_cycles", busyCycles, 192);
    checkOutput("bist_busy_at_done", hostIf.o_busy, 0);
    checkOutput("bist_fail", bistFail, expFail);
    checkOutput("bist_no_host_done", sawHostDone, 0);
    @(negedge clock);
    checkOutput("bist_done_pulse", bistDone, 0);
    for (int a = 0; a < 64; a++) refMem[a] = 8'(a) ^ 8'hA5;
  endtask
`endif

  initial begin
    errors         = 0;
    checks         = 0;
    rstN           = 1'b0;
    bistStart      = 1'b0;
    stuckFault     = 1'b0;
    hostIf.i_req   = 1'b0;
    hostIf.i_wr    = 1'b0;
    hostIf.i_addr  = '0;
    hostIf.i_wdata = '0;
    for (int a = 0; a < 64; a++) refMem[a] = 8'h00;

    // Reset state.
    #12;
    checkOutput("rst_ce", ramCe, 0);
    checkOutput("rst_rw", ramRw, 0);
    checkOutput("rst_addr", ramAddr, 0);
    checkOutput("rst_busy", hostIf.o_busy, 0);
    checkOutput("rst_done", hostIf.o_done, 0);
    checkOutput("rst_rdata", hostIf.o_rdata, 0);
    checkOutput("rst_bus", ramBus, 8'hFF);
    checkOutput("rst_bist_done", bistDone, 0);
    checkOutput("rst_bist_fail", bistFail, 0);
    @(negedge clock);
    rstN = 1'b1;
    @(negedge clock);

    // Basic write then read of the same word.
    applyStimulus(1'b1, 6'd5, 8'h3C);
    applyStimulus(1'b0, 6'd5, 8'h00);

    // Extreme addresses with extreme data; the tasks chain, so each new
    // request is raised in the previous o_done cycle.
    applyStimulus(1'b1, 6'd0, 8'h00);
    applyStimulus(1'b1, 6'd63, 8'hFF);
    applyStimulus(1'b0, 6'd0, 8'h00);
    applyStimulus(1'b0, 6'd63, 8'h00);
    applyStimulus(1'b0, 6'd5, 8'h00);

    // Request held high through a busy read with a different address.
    applyStimulus(1'b1, 6'd9, 8'h5A);
    hostIf.i_req  = 1'b1;
    hostIf.i_wr   = 1'b0;
    hostIf.i_addr = 6'd9;
    @(negedge clock);
    hostIf.i_wr    = 1'b1;
    hostIf.i_addr  = 6'd10;
    hostIf.i_wdata = 8'hEE;
    checkOutput("hold_addr_c1", ramAddr, 9);
    @(negedge clock);
    checkOutput("hold_addr_c2", ramAddr, 9);
    checkOutput("hold_done_c2", hostIf.o_done, 0);
    @(negedge clock);
    hostIf.i_req = 1'b0;
    checkOutput("hold_done", hostIf.o_done, 1);
    checkOutput("hold_rdata", hostIf.o_rdata, 8'h5A);
    @(negedge clock);
    checkOutput("hold_single_done", hostIf.o_done, 0);
    checkOutput("hold_idle_busy", hostIf.o_busy, 0);
    checkOutput("hold_idle_ce", ramCe, 0);
    applyStimulus(1'b0, 6'd10, 8'h00);

    // Reset in the middle of a read's data phase.
    applyStimulus(1'b0, 6'd5, 8'h00);
    @(negedge clock);
    hostIf.i_req  = 1'b1;
    hostIf.i_wr   = 1'b0;
    hostIf.i_addr = 6'd9;
    @(negedge clock);
    hostIf.i_req = 1'b0;
    @(negedge clock);
    checkOutput("pre_rst_rw", ramRw, 1);
    #1 rstN = 1'b0;
    #1;
    checkOutput("mid_rst_ce", ramCe, 0);
    checkOutput("mid_rst_rw", ramRw, 0);
    checkOutput("mid_rst_addr", ramAddr, 0);
    checkOutput("mid_rst_busy", hostIf.o_busy, 0);
    checkOutput("mid_rst_done", hostIf.o_done, 0);
    checkOutput("mid_rst_rdata", hostIf.o_rdata, 0);
    checkOutput("mid_rst_bus", ramBus, 8'hFF);
    @(negedge clock);
    rstN = 1'b1;
    @(negedge clock);
    checkOutput("post_rst_done", hostIf.o_done, 0);
    checkOutput("post_rst_busy", hostIf.o_busy, 0);

    // Randomized mix of back-to-back reads and writes.
    for (int n = 0; n < 40; n++) begin
      logic       rWr;
      logic [5:0] rAddr;
      logic [7:0] rData;
      rWr   = 1'($urandom_range(0, 1));
      rAddr = 6'($urandom_range(0, 63));
      rData = 8'($urandom_range(0, 255));
      applyStimulus(rWr, rAddr, rData);
    end

`ifdef SRAM_CTRL_BIST_EN
    // Self-test on a good RAM, then with a stuck bit, then good again.
    @(negedge clock);
    runBist(1'b0);
    applyStimulus(1'b0, 6'd17, 8'h00);
    applyStimulus(1'b0, 6'd3, 8'h00);
    @(negedge clock);
    stuckFault = 1'b1;
    runBist(1'b1);
    stuckFault = 1'b0;
    runBist(1'b0);
`endif

    @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
